// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 encodings, FSM states,
// access-size decode helpers.
package mem_access_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_RMW_WR
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    // Reserved encodings fall through to a full-word access.
    function automatic size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Word-wide data-memory port: combinational read, write on the clock edge.
interface mem_access_stage_if
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic [XLEN-1:0] addr;
    logic            we;
    logic [XLEN-1:0] din;
    logic [XLEN-1:0] dout;

    modport master (output addr, output we, output din, input dout);
    modport slave  (input addr, input we, input din, output dout);
endinterface

// File: rtl/mem_access_stage_lane_unit.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and
// store merge into a read word. Lane selection assumes a 32-bit word.
module mem_lane_unit
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] word,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_data
);
    localparam int LANES = XLEN / 8;

    size_t            size;
    logic             is_unsigned;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [LANES-1:0] lane_en;
    logic [XLEN-1:0]  wdata_rep;

    assign size        = f3_size(funct3);
    assign is_unsigned = f3_unsigned(funct3);
    assign byte_sel    = word[8*addr_lo +: 8];
    assign half_sel    = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {{(XLEN-8){1'b0}}, byte_sel}
                                             : {{(XLEN-8){byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = is_unsigned ? {{(XLEN-16){1'b0}}, half_sel}
                                             : {{(XLEN-16){half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

    // Store data is replicated across all lanes; lane_en picks which lanes replace the read word.
    always_comb begin
        lane_en   = '1;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                lane_en   = LANES'(1) << addr_lo;
                wdata_rep = {LANES{wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_en   = addr_lo[1] ? LANES'(4'b1100) : LANES'(4'b0011);
                wdata_rep = {(LANES/2){wdata[15:0]}};
            end
            default: begin
                lane_en   = '1;
                wdata_rep = wdata;
            end
        endcase
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_merge
        assign store_data[8*gi +: 8] = lane_en[gi] ? wdata_rep[8*gi +: 8] : word[8*gi +: 8];
    end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: loads with extension, word stores, sub-word stores as a
// two-cycle read-modify-write, MEM/WB register. Option: MEM_STAGE_MISALIGN_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int              XLEN          = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC_DATA = '0
) (
    input  logic              clk,
    input  logic              rstn,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              in_reg_write,

    mem_access_stage_if.master dm,

    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data
`ifdef MEM_STAGE_MISALIGN_EN
    ,
    output logic              wb_misalign
`endif
);
    state_t          state_reg;
    logic [XLEN-1:0] rmw_addr_reg;
    logic [XLEN-1:0] rmw_data_reg;
    logic [4:0]      rmw_rd_reg;

    logic            wb_valid_reg;
    logic            wb_reg_write_reg;
    logic [4:0]      wb_rd_reg;
    logic [XLEN-1:0] wb_data_reg;

    logic            accept;
    logic            is_store;
    logic            is_load;
    logic            sub_store;
    logic            misalign;
    size_t           size;
    logic [XLEN-1:0] aligned_addr;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] store_data;

    assign in_ready     = (state_reg == ST_IDLE);
    assign accept       = in_valid & in_ready;
    assign is_store     = in_mem_write;
    assign is_load      = in_mem_read & ~in_mem_write;
    assign size         = f3_size(in_funct3);
    assign sub_store    = is_store & (size != SZ_WORD);
    assign aligned_addr = {in_addr[XLEN-1:2], 2'b00};

`ifdef MEM_STAGE_MISALIGN_EN
    logic wb_misalign_reg;

    assign misalign    = (is_load | is_store) &
                         (((size == SZ_HALF) & in_addr[0]) | ((size == SZ_WORD) & (|in_addr[1:0])));
    assign wb_misalign = wb_misalign_reg;
`else
    assign misalign = 1'b0;
`endif

    mem_lane_unit #(.XLEN(XLEN)) u_lane (
        .funct3     (in_funct3),
        .addr_lo    (in_addr[1:0]),
        .word       (dm.dout),
        .wdata      (in_wdata),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // The RMW write cycle replays the latched word; otherwise the port follows the incoming entry.
    assign dm.addr = (state_reg == ST_RMW_WR) ? rmw_addr_reg : aligned_addr;
    assign dm.din  = (state_reg == ST_RMW_WR) ? rmw_data_reg : in_wdata;
    assign dm.we   = rstn & ((state_reg == ST_RMW_WR) |
                             (accept & is_store & ~sub_store & ~misalign));

    assign wb_valid     = wb_valid_reg;
    assign wb_reg_write = wb_reg_write_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_data      = wb_data_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= ST_IDLE;
            rmw_addr_reg     <= '0;
            rmw_data_reg     <= '0;
            rmw_rd_reg       <= '0;
            wb_valid_reg     <= 1'b0;
            wb_reg_write_reg <= 1'b0;
            wb_rd_reg        <= '0;
            wb_data_reg      <= RESET_PC_DATA;
`ifdef MEM_STAGE_MISALIGN_EN
            wb_misalign_reg  <= 1'b0;
`endif
        end else begin
            wb_valid_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (sub_store && !misalign) begin
                            rmw_addr_reg <= aligned_addr;
                            rmw_data_reg <= store_data;
                            rmw_rd_reg   <= in_rd;
                            state_reg    <= ST_RMW_WR;
                        end else begin
                            wb_valid_reg     <= 1'b1;
                            wb_rd_reg        <= in_rd;
                            wb_reg_write_reg <= in_reg_write & ~is_store & ~misalign;
                            wb_data_reg      <= (is_load && !misalign) ? load_data : in_addr;
`ifdef MEM_STAGE_MISALIGN_EN
                            wb_misalign_reg  <= misalign;
`endif
                        end
                    end
                end
                ST_RMW_WR: begin
                    wb_valid_reg     <= 1'b1;
                    wb_reg_write_reg <= 1'b0;
                    wb_rd_reg        <= rmw_rd_reg;
                    wb_data_reg      <= rmw_addr_reg;
`ifdef MEM_STAGE_MISALIGN_EN
                    wb_misalign_reg  <= 1'b0;
`endif
                    state_reg        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table plus scoreboard on the
// MEM/WB output, with hand-written reset and idle sequences.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mem_read = 1'b0;
    logic        in_mem_write = 1'b0;
    logic [2:0]  in_funct3 = 3'b010;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_write = 1'b0;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef MEM_STAGE_MISALIGN_EN
    logic        wb_misalign;
`endif

    always #5 clk = ~clk;

    mem_access_stage_if #(.XLEN(32)) dm ();

    mem_access_stage #(.XLEN(32), .RESET_PC_DATA(32'h0000_0000)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_funct3    (in_funct3),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .dm           (dm.master),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
`ifdef MEM_STAGE_MISALIGN_EN
        ,
        .wb_misalign  (wb_misalign)
`endif
    );

    // Data memory model; the bench preloads words through the same process.
    logic [31:0] mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    always @(posedge clk) begin
        if (dm.we) mem[dm.addr[7:2]] <= dm.din;
        if (pre_en) mem[pre_idx] <= pre_val;
    end
    assign dm.dout = mem[dm.addr[7:2]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        logic        chk_data;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];

    always @(negedge clk) begin
        if (rstn && wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected_retire", 32'(wb_rd), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("retire rd=%0d reg_write=%0b data=%h (want rd=%0d reg_write=%0b)",
                         wb_rd, wb_reg_write, wb_data, e.rd, e.rw);
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                if (e.chk_data) chk("wb_data", wb_data, e.data);
`ifdef MEM_STAGE_MISALIGN_EN
                chk("wb_misalign", 32'(wb_misalign), 32'(e.mis));
`endif
            end
        end
    end

    typedef struct {
        logic        rd_en;
        logic        wr_en;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        use_pre;
        logic [31:0] pre;
        logic [31:0] exp_data;
        logic        exp_rw;
        logic [31:0] exp_mem;
        logic        mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic use_pre, input logic [31:0] pre,
                                input logic [31:0] exp_data, input logic exp_rw,
                                input logic [31:0] exp_mem, input logic mis);
        vec_t v;
        v.rd_en = rd_en; v.wr_en = wr_en; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.use_pre = use_pre; v.pre = pre; v.exp_data = exp_data; v.exp_rw = exp_rw;
        v.exp_mem = exp_mem; v.mis = mis;
        return v;
    endfunction

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic apply(input int i, input vec_t v);
        logic        mis_now;
        logic        sub;
        logic        direct_we;
        logic [31:0] exp_mem;
        exp_t        e;
        mis_now = 1'b0;
`ifdef MEM_STAGE_MISALIGN_EN
        mis_now = v.mis;
`endif
        sub       = v.wr_en && (v.f3 != F3_W) && !mis_now;
        direct_we = v.wr_en && !sub && !mis_now;
        exp_mem   = mis_now ? v.pre : v.exp_mem;
        if (v.use_pre) preload(v.addr[7:2], v.pre);

        @(posedge clk); #1;
        in_valid = 1'b1; in_mem_read = v.rd_en; in_mem_write = v.wr_en;
        in_funct3 = v.f3; in_addr = v.addr; in_wdata = v.wdata;
        in_rd = 5'(i + 1); in_reg_write = 1'b1;
        e.rd = 5'(i + 1); e.rw = mis_now ? 1'b0 : v.exp_rw; e.data = v.exp_data;
        e.chk_data = !v.wr_en && !mis_now; e.mis = mis_now;
        sb_q.push_back(e);

        @(negedge clk);
        chk($sformatf("v%0d_in_ready_c1", i), 32'(in_ready), 32'd1);
        chk($sformatf("v%0d_dm_we_c1", i), 32'(dm.we), 32'(direct_we));
        chk($sformatf("v%0d_dm_addr_c1", i), dm.addr, {v.addr[31:2], 2'b00});
        if (direct_we) chk($sformatf("v%0d_dm_din", i), dm.din, v.wdata);

        @(posedge clk); #1;
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        if (sub) begin
            @(negedge clk);
            chk($sformatf("v%0d_in_ready_rmw", i), 32'(in_ready), 32'd0);
            chk($sformatf("v%0d_dm_we_rmw", i), 32'(dm.we), 32'd1);
            chk($sformatf("v%0d_dm_din_rmw", i), dm.din, exp_mem);
            @(posedge clk); #1;
        end
        chk($sformatf("v%0d_mem_word", i), mem[v.addr[7:2]], exp_mem);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with a would-be word store presented to prove dm_we is held low.
        in_valid = 1'b1; in_mem_write = 1'b1; in_funct3 = F3_W; in_addr = 32'h40;
        #3;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'h0000_0000);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_dm_we", 32'(dm.we), 32'd0);
        in_valid = 1'b0; in_mem_write = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        //                  rd wr f3      addr           wdata          pre pre_val        exp_data       rw exp_mem        mis
        vecs.push_back(mk(1, 0, F3_B,  32'h13,        32'h0,         1, 32'h80FF_1234, 32'hFFFF_FF80, 1, 32'h80FF_1234, 0));
        vecs.push_back(mk(1, 0, F3_BU, 32'h13,        32'h0,         0, 32'h0,         32'h0000_0080, 1, 32'h80FF_1234, 0));
        vecs.push_back(mk(1, 0, F3_H,  32'h12,        32'h0,         1, 32'h8001_7FFF, 32'hFFFF_8001, 1, 32'h8001_7FFF, 0));
        vecs.push_back(mk(1, 0, F3_HU, 32'h10,        32'h0,         0, 32'h0,         32'h0000_7FFF, 1, 32'h8001_7FFF, 0));
        vecs.push_back(mk(1, 0, F3_B,  32'h10,        32'h0,         1, 32'h0000_FE7F, 32'h0000_007F, 1, 32'h0000_FE7F, 0));
        vecs.push_back(mk(1, 0, F3_B,  32'h11,        32'h0,         0, 32'h0,         32'hFFFF_FFFE, 1, 32'h0000_FE7F, 0));
        vecs.push_back(mk(1, 0, 3'b011, 32'h18,       32'h0,         1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 0));
        vecs.push_back(mk(1, 0, 3'b110, 32'h18,       32'h0,         0, 32'h0,         32'hCAFE_F00D, 1, 32'hCAFE_F00D, 0));
        vecs.push_back(mk(0, 0, F3_W,  32'h1234_5678, 32'h0,         1, 32'h0,         32'h1234_5678, 1, 32'h0,         0));
        vecs.push_back(mk(0, 1, F3_W,  32'h20,        32'hDEAD_BEEF, 1, 32'h0,         32'h0,         0, 32'hDEAD_BEEF, 0));
        vecs.push_back(mk(0, 1, F3_B,  32'h21,        32'h0000_00AB, 1, 32'h1122_3344, 32'h0,         0, 32'h1122_AB44, 0));
        vecs.push_back(mk(1, 0, F3_W,  32'h20,        32'h0,         0, 32'h0,         32'h1122_AB44, 1, 32'h1122_AB44, 0));
        vecs.push_back(mk(0, 1, F3_H,  32'h22,        32'hFFFF_5566, 1, 32'h1122_3344, 32'h0,         0, 32'h5566_3344, 0));
        vecs.push_back(mk(0, 1, F3_B,  32'h27,        32'h1234_56CD, 1, 32'h0,         32'h0,         0, 32'hCD00_0000, 0));
        vecs.push_back(mk(1, 1, F3_W,  32'h2C,        32'h0102_0304, 1, 32'h0,         32'h0,         0, 32'h0102_0304, 0));
        vecs.push_back(mk(1, 0, F3_H,  32'h11,        32'h0,         1, 32'hAAAA_8001, 32'hFFFF_8001, 1, 32'hAAAA_8001, 1));
        vecs.push_back(mk(0, 1, F3_W,  32'h32,        32'h0BAD_F00D, 1, 32'h7777_7777, 32'h0,         0, 32'h0BAD_F00D, 1));
        vecs.push_back(mk(1, 0, F3_W,  32'h24,        32'h0,         1, 32'h600D_600D, 32'h600D_600D, 1, 32'h600D_600D, 0));

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // With no new entry the valid drops and the remaining fields hold the last retire.
        @(negedge clk);
        @(negedge clk);
        chk("idle_wb_valid", 32'(wb_valid), 32'd0);
        chk("idle_wb_data_hold", wb_data, 32'h600D_600D);
        chk("idle_wb_rd_hold", 32'(wb_rd), 32'd18);

        // Reset during RMW_WR: the write must not reach memory.
        preload(6'h10, 32'hA1B2_C3D4);
        @(posedge clk); #1;
        in_valid = 1'b1; in_mem_write = 1'b1; in_funct3 = F3_H;
        in_addr = 32'h42; in_wdata = 32'h0000_5566; in_rd = 5'd7;
        @(negedge clk);
        chk("rmwrst_dm_we_c1", 32'(dm.we), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_mem_write = 1'b0;
        chk("rmwrst_in_ready_c2", 32'(in_ready), 32'd0);
        #1 rstn = 1'b0;
        #1;
        chk("rmwrst_dm_we", 32'(dm.we), 32'd0);
        chk("rmwrst_in_ready", 32'(in_ready), 32'd1);
        chk("rmwrst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rmwrst_wb_reg_write", 32'(wb_reg_write), 32'd0);
        chk("rmwrst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rmwrst_wb_data", wb_data, 32'h0000_0000);
`ifdef MEM_STAGE_MISALIGN_EN
        chk("rmwrst_wb_misalign", 32'(wb_misalign), 32'd0);
`endif
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rmwrst_mem_unchanged", mem[16], 32'hA1B2_C3D4);
        @(negedge clk);
        chk("rmwrst_no_retire", 32'(wb_valid), 32'd0);

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
